// File: rtl/logic_cell_stim_seq.sv
// rtl/logic_cell_stim_seq.sv - exhaustive 11-bit stimulus sweep for a logic cell with MISR response compaction
module logic_cell_stim_seq #(
    parameter int          SETTLE    = 2,
    parameter logic [15:0] MISR_POLY = 16'h1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  resp,
    output logic [10:0] stim_vec,
    output logic [10:0] vec_idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0]  SETTLE_CNT = 4'(SETTLE);
    localparam logic [10:0] LAST_IDX   = 11'h7FF;

    state_t      state_q, state_d;
    logic [10:0] vec_idx_q, vec_idx_d;
    logic [10:0] stim_vec_q, stim_vec_d;
    logic [15:0] signature_q, signature_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        in_sweep;

    assign in_sweep = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);

    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        stim_vec_d  = stim_vec_q;
        signature_d = signature_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // Abort discards the sweep before any MISR update on the same edge.
        if (abort && in_sweep) begin
            state_d    = S_IDLE;
            vec_idx_d  = 11'd0;
            stim_vec_d = 11'd0;
            cnt_d      = 4'd0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d     = S_APPLY;
                        vec_idx_d   = 11'd0;
                        stim_vec_d  = 11'd0;
                        signature_d = 16'h0000;
                        busy_d      = 1'b1;
                    end
                end
                S_APPLY: begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_CNT;
                end
                S_SETTLE: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = S_CAPTURE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    signature_d = {signature_q[14:0], 1'b0}
                                ^ (signature_q[15] ? MISR_POLY : 16'h0000)
                                ^ {12'h000, resp};
                    if (vec_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_APPLY;
                        vec_idx_d  = vec_idx_q + 11'd1;
                        stim_vec_d = vec_idx_q + 11'd1;
                    end
                end
                S_DONE: begin
                    state_d    = S_IDLE;
                    vec_idx_d  = 11'd0;
                    stim_vec_d = 11'd0;
                end
                default: begin
                    state_d    = S_IDLE;
                    vec_idx_d  = 11'd0;
                    stim_vec_d = 11'd0;
                    busy_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_idx_q   <= 11'd0;
            stim_vec_q  <= 11'd0;
            signature_q <= 16'h0000;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            stim_vec_q  <= stim_vec_d;
            signature_q <= signature_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign stim_vec  = stim_vec_q;
    assign vec_idx   = vec_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = signature_q;

endmodule

// File: tb/tb_logic_cell_stim_seq.sv
// tb/tb_logic_cell_stim_seq.sv - directed bench for logic_cell_stim_seq
module tb_logic_cell_stim_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  resp;
    logic [10:0] stim_vec;
    logic [10:0] vec_idx;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    int tests_run;
    int tests_failed;

    logic_cell_stim_seq #(.SETTLE(2), .MISR_POLY(16'h1021)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .resp      (resp),
        .stim_vec  (stim_vec),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge; returns at the negedge of cycle 0 (vector 0 APPLY).
    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_sweep();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        resp  = 4'h0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, stim_vec, vec_idx, signature} !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b stim=%h idx=%h sig=%h, want all 0",
                     busy, done, stim_vec, vec_idx, signature);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || stim_vec !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_first_start: got busy=%b stim=%h, want busy=1 stim=0", busy, stim_vec);
        end
        stop_sweep();
    endtask

    task automatic test_full_sweep();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        resp = 4'h0;
        kick();
        for (int c = 0; c < 8200; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        tests_run++;
        if (busy_cnt != 8192) begin
            tests_failed++;
            $display("FAIL sweep_busy_cycles: got %0d, want 8192", busy_cnt);
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL sweep_done_pulses: got %0d, want 1", done_cnt);
        end
        tests_run++;
        if (signature !== 16'h0000) begin
            tests_failed++;
            $display("FAIL sweep_signature: got %h, want 0000", signature);
        end
        tests_run++;
        if (stim_vec !== 11'd0 || vec_idx !== 11'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_idle_after: got stim=%h idx=%h busy=%b, want 0 0 0", stim_vec, vec_idx, busy);
        end
    endtask

    task automatic test_vector_order();
        logic [10:0] exp_v;
        kick();
        for (int c = 0; c < 12; c++) begin
            exp_v = 11'(c / 4);
            tests_run++;
            if (stim_vec !== exp_v || vec_idx !== exp_v) begin
                tests_failed++;
                $display("FAIL order_cycle%0d: got stim=%h idx=%h, want %h", c, stim_vec, vec_idx, exp_v);
            end
            resp = ((c % 4) == 3) ? 4'h0 : 4'hF;
            @(negedge clk);
        end
        tests_run++;
        if (signature !== 16'h0000 || stim_vec !== 11'd3) begin
            tests_failed++;
            $display("FAIL order_resp_masked: got sig=%h stim=%h, want 0000 003", signature, stim_vec);
        end
        resp = 4'h0;
        stop_sweep();
    endtask

    task automatic test_misr_abort();
        int done_cnt;
        done_cnt = 0;
        kick();
        for (int c = 0; c < 9; c++) begin
            resp = (c == 3) ? 4'h1 : ((c == 7) ? 4'h0 : 4'hC);
            if (c == 4) begin
                tests_run++;
                if (signature !== 16'h0001) begin
                    tests_failed++;
                    $display("FAIL misr_vec0: got %h, want 0001", signature);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (signature !== 16'h0002) begin
            tests_failed++;
            $display("FAIL misr_vec1: got %h, want 0002", signature);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || stim_vec !== 11'd0 || vec_idx !== 11'd0 || signature !== 16'h0002) begin
            tests_failed++;
            $display("FAIL abort_settle: got busy=%b stim=%h idx=%h sig=%h, want 0 0 0 0002",
                     busy, stim_vec, vec_idx, signature);
        end
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        tests_run++;
        if (done_cnt != 0 || signature !== 16'h0002) begin
            tests_failed++;
            $display("FAIL abort_no_done: got done_cnt=%0d sig=%h, want 0 0002", done_cnt, signature);
        end
    endtask

    task automatic test_collisions();
        kick();
        for (int c = 0; c < 9; c++) begin
            start = (c == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (stim_vec !== 11'd2 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_midsweep: got stim=%h busy=%b, want 002 1", stim_vec, busy);
        end
        stop_sweep();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || stim_vec !== 11'd0) begin
            tests_failed++;
            $display("FAIL start_abort_idle: got busy=%b stim=%h, want 0 0", busy, stim_vec);
        end
    endtask

    task automatic test_async_reset();
        resp = 4'h5;
        kick();
        repeat (1025) @(negedge clk);
        tests_run++;
        if (vec_idx !== 11'h100 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre_idx: got idx=%h busy=%b, want 100 1", vec_idx, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, stim_vec, vec_idx, signature} !== 40'h0) begin
            tests_failed++;
            $display("FAIL async_clear: got busy=%b done=%b stim=%h idx=%h sig=%h, want all 0",
                     busy, done, stim_vec, vec_idx, signature);
        end
        @(negedge clk);
        rst_n = 1'b1;
        resp  = 4'h0;
        kick();
        tests_run++;
        if (busy !== 1'b1 || stim_vec !== 11'd0 || vec_idx !== 11'd0 || signature !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_restart: got busy=%b stim=%h idx=%h sig=%h, want 1 0 0 0000",
                     busy, stim_vec, vec_idx, signature);
        end
        stop_sweep();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        resp  = 4'h0;
        test_reset();
        test_full_sweep();
        test_vector_order();
        test_misr_abort();
        test_collisions();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
